// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: transfer sizes,
// the load/store engine state encoding and an alignment helper.
package mem_pkg;

  // Transfer size encodings as presented by the pipeline.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Load/store engine states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STORE_W = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_WR  = 3'd4,
    ST_ERR     = 3'd5,
    ST_RESP    = 3'd6
  } state_e;

  // True when the size is legal and the low address bits are aligned to it.
  function automatic logic is_legal_access(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (addr_lo[0] == 1'b0);
      SIZE_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for a 32-bit word: extracts and extends the
// addressed byte/half for loads, and merges store data into the addressed
// lane for read-modify-write. Purely combinational so it can be shared with
// the instruction-fetch path.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        fill_s;

  // Select the addressed byte and half lanes from the word.
  always_comb begin
    byte_s = word_i[{offset_i, 3'b000} +: 8];
    half_s = word_i[{offset_i[1], 4'b0000} +: 16];
  end

  // Extend the addressed lane to 32 bits; word loads pass straight through.
  always_comb begin
    fill_s      = 1'b0;
    load_data_o = 32'd0;
    case (size_i)
      SIZE_B: begin
        fill_s      = signed_i & byte_s[7];
        load_data_o = {{24{fill_s}}, byte_s};
      end
      SIZE_H: begin
        fill_s      = signed_i & half_s[15];
        load_data_o = {{16{fill_s}}, half_s};
      end
      SIZE_W: begin
        load_data_o = word_i;
      end
      default: begin
        load_data_o = 32'd0;
      end
    endcase
  end

  // Replace only the addressed lane with the low bits of the store data.
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SIZE_B:  merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SIZE_H:  merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between the CPU memory stage and a word-wide data RAM.
// Sub-word stores are done as read-modify-write; misaligned or illegal
// requests never touch the RAM but still return a registered response.
// All outputs come straight from flops, computed from the next state.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_exception,
  output logic                  ram_readEnable,
  output logic                  ram_writeEnable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_writeDataIn,
  input  logic [31:0]           ram_readData,
  input  logic                  ram_exception
);

  // Request latches.
  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  // Output flops.
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_exc_q, resp_exc_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;

  logic                  accept_s;
  logic                  exc_s;
  logic [31:0]           load_data_s;
  logic [31:0]           merged_s;

  // Lane extract/extend uses the live RAM word against the latched request.
  mem_lane_align u_lane_align (
    .word_i      (ram_readData),
    .offset_i    (addr_q[1:0]),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Capture the request fields on acceptance, hold them otherwise.
  always_comb begin
    accept_s = req_valid & (state_q == ST_IDLE);
    if (accept_s) begin
      write_d  = req_write;
      size_d   = req_size;
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end else begin
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
    end
  end

  // Next-state logic; a RAM fault on the RMW read skips the write entirely.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (!is_legal_access(req_size, req_addr[1:0])) begin
          state_d = ST_ERR;
        end else if (!req_write) begin
          state_d = ST_LOAD;
        end else if (req_size == SIZE_W) begin
          state_d = ST_STORE_W;
        end else begin
          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:    state_d = ST_RESP;
      ST_STORE_W: state_d = ST_RESP;
      ST_RMW_RD: begin
        if (ram_exception) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_RMW_WR;
        end
      end
      ST_RMW_WR:  state_d = ST_RESP;
      ST_ERR:     state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Exception flag for the response: alignment error or a fault seen by the RAM.
  always_comb begin
    case (state_q)
      ST_LOAD, ST_STORE_W, ST_RMW_RD, ST_RMW_WR: exc_s = ram_exception;
      ST_ERR:                                    exc_s = 1'b1;
      default:                                   exc_s = 1'b0;
    endcase
  end

  // Decode the next-cycle outputs from the next state so they can be registered.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    rd_en_d      = (state_d == ST_LOAD) || (state_d == ST_RMW_RD);
    wr_en_d      = (state_d == ST_STORE_W) || (state_d == ST_RMW_WR);
    resp_valid_d = (state_d == ST_RESP);
    resp_exc_d   = (state_d == ST_RESP) & exc_s;

    if (rd_en_d || wr_en_d) begin
      ram_addr_d = {addr_d[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      ram_addr_d = {ADDR_WIDTH{1'b0}};
    end

    if (state_d == ST_STORE_W) begin
      ram_wdata_d = wdata_d;
    end else if (state_d == ST_RMW_WR) begin
      ram_wdata_d = merged_s;
    end else begin
      ram_wdata_d = 32'd0;
    end

    // Only a clean load returns data; stores and faults return zero.
    if ((state_d == ST_RESP) && (state_q == ST_LOAD) && !write_q && !ram_exception) begin
      resp_rdata_d = load_data_s;
    end else begin
      resp_rdata_d = 32'd0;
    end
  end

  // State, request latches and output flops; reset abandons any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= 32'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_exc_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ram_addr_q   <= {ADDR_WIDTH{1'b0}};
      ram_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign req_ready       = ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_exception  = resp_exc_q;
  assign ram_readEnable  = rd_en_q;
  assign ram_writeEnable = wr_en_q;
  assign ram_address     = ram_addr_q;
  assign ram_writeDataIn = ram_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store engine between the CPU memory stage and the word-wide data RAM.
- Accepts byte, halfword and word loads and stores from the pipeline.
- Checks alignment, then drives the RAM's word-only read/write port.
- Byte and halfword stores use a read-modify-write sequence; loads are extracted and sign- or zero-extended.
- Returns one response pulse per accepted request.

Parameters:
- ADDR_WIDTH, 14: byte-address width; matches the RAM address port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exception  out  1  misaligned, illegal size, or RAM exception; qualified by resp_valid.
- ram_readEnable  out  1  RAM read enable.
- ram_writeEnable  out  1  RAM write enable.
- ram_address  out  ADDR_WIDTH  word-aligned address; bits [1:0] always 0.
- ram_writeDataIn  out  32  full word to write.
- ram_readData  in  32  combinational read data, valid in the same cycle as readEnable.
- ram_exception  in  1  combinational fault for the current address.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except req_ready=1; internal latches cleared.
- Accept: on a cycle with req_valid & req_ready, latch write, size, signed, addr and wdata. req_ready drops the next cycle.
- Alignment:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size=3 is always illegal.
  - A violation goes to state ERR; no RAM enable is ever asserted for it.
- States and transitions:
  - IDLE -> LOAD | STORE_W | RMW_RD | ERR, on accept.
  - LOAD: readEnable=1. Capture the extracted word. Next RESP.
  - STORE_W: writeEnable=1, data=wdata. Next RESP.
  - RMW_RD: readEnable=1. Latch the merged word: the byte or half lane is replaced by wdata[7:0] or wdata[15:0]. Next RMW_WR.
  - RMW_WR: writeEnable=1, write the merged word. Next RESP.
  - ERR: next RESP with the exception flag set.
  - RESP: resp_valid=1 for one cycle. Next IDLE. A new request is accepted no earlier than the cycle after RESP.
- Latency (request accepted at edge T):
  - load / word store / error: resp_valid in cycle T+2.
  - sub-word store: resp_valid in cycle T+3.
  - Error requests still pass through one ERR cycle so that RESP is registered.
- Lane mapping is little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0].
  - half h = bits [16h+15:16h], with h = addr[1].
- Extension: byte/half loads fill the upper bits with the lane MSB when req_signed=1, else with 0. Word loads ignore req_signed.
- RAM exception:
  - If ram_exception=1 during LOAD or RMW_RD, set the exception flag.
  - In RMW_RD, also skip RMW_WR and go directly to RESP; no write is issued.
  - If ram_exception=1 during STORE_W, the write is still driven (the RAM owns suppression) and the flag is set.
- ram_address = {latched addr[ADDR_WIDTH-1:2], 2'b00}, driven only in RAM states, otherwise 0.
- Enables and write data are 0 outside their states. readEnable and writeEnable are never high together.
- Reset asserted mid-operation returns to IDLE immediately. A pending RMW write is abandoned and no resp_valid is issued.

Decomposition:
- Shared package mem_pkg: size encodings (SIZE_B=0, SIZE_H=1, SIZE_W=2) and the state enum.
- Sub-module mem_lane_align: combinational lane extract/extend for loads and lane merge for stores. Reuse it in the instruction-fetch path later.

Test Plan:
- RAM word 0x10 preloaded with 0x8899AABB. Load byte, addr=0x13, signed -> resp_rdata=0xFFFFFF88 at T+2. Same load unsigned -> 0x00000088.
- Store half, addr=0x12, wdata=0x1234, over 0x8899AABB -> read at T+1 then write at T+2 with ram_writeDataIn=0x1234AABB; resp at T+3. A subsequent word load returns 0x1234AABB.
- Store word, addr=0x20, wdata=0xDEADBEEF -> single writeEnable cycle at T+1 with ram_address=0x20; resp at T+2 with exception=0.
- Load word, addr=0x22 -> no RAM enables at any cycle; resp_valid at T+2 with exception=1 and rdata=0. The same result for size=3.
- ram_exception forced high during the RMW read of a byte store -> writeEnable never asserted; resp at T+2 with exception=1.
- reset pulled low during RMW_RD -> all outputs 0, req_ready=1 asynchronously; no resp_valid follows. A new request is accepted on the first edge after release.
